// File: rtl/pa_arith_pkg.sv
// Shared definitions for the iterative arithmetic blocks (multiplier and divider).
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pa_arith_pkg;

  // Two-state iteration controller shared by the multiply-add and the divider.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pa_iter_state_t;

  // Iteration counter width for an N-step loop. The extra bit leaves headroom
  // so the counter can reach N-1 for any N.
  function automatic int pa_cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/pa_shift_add_step.sv
// One radix-2 shift-add multiply iteration, purely combinational.
// Latency: 0 cycles.
// Backpressure: none; the caller decides when to register the outputs.
module pa_shift_add_step #(
  parameter int SIZE_DATA = 32
) (
  input  logic [2*SIZE_DATA-1:0] acc_i,
  input  logic [2*SIZE_DATA-1:0] mcand_sh_i,
  input  logic [SIZE_DATA-1:0]   mplier_sh_i,
  output logic [2*SIZE_DATA-1:0] acc_o,
  output logic [2*SIZE_DATA-1:0] mcand_sh_o,
  output logic [SIZE_DATA-1:0]   mplier_sh_o
);

  // Add the shifted multiplicand when the current multiplier LSB is set. The
  // carry out of the 2N-bit add is dropped: A*B+C never exceeds 2^2N - 2^N.
  always_comb begin
    acc_o       = mplier_sh_i[0] ? (acc_i + mcand_sh_i) : acc_i;
    mcand_sh_o  = mcand_sh_i << 1;
    mplier_sh_o = mplier_sh_i >> 1;
  end

endmodule

// File: rtl/pa_mul_add_algo.sv
// Sequential unsigned multiply-accumulate: o_product = A*B + C, one multiplier bit per clock.
// Latency: N cycles from the capture edge to o_valid; one result every N+1 cycles.
// Backpressure: none; starts are accepted only in IDLE, and i_en_multiply is ignored while busy.
module pa_mul_add_algo
  import pa_arith_pkg::*;
#(
  parameter int SIZE_DATA = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en_multiply,
  input  logic [SIZE_DATA-1:0]   i_multiplicand,
  input  logic [SIZE_DATA-1:0]   i_multiplier,
  input  logic [SIZE_DATA-1:0]   i_addend,
  output logic [2*SIZE_DATA-1:0] o_product,
  output logic                   o_valid,
  output logic                   o_busy
);

  localparam int                  CNT_W    = pa_cnt_w(SIZE_DATA);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(SIZE_DATA - 1);

  pa_iter_state_t         state_q, state_d;
  logic [2*SIZE_DATA-1:0] acc_q, acc_d;
  logic [2*SIZE_DATA-1:0] mcand_sh_q, mcand_sh_d;
  logic [SIZE_DATA-1:0]   mplier_sh_q, mplier_sh_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2*SIZE_DATA-1:0] product_q, product_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;

  logic [2*SIZE_DATA-1:0] step_acc;
  logic [2*SIZE_DATA-1:0] step_mcand_sh;
  logic [SIZE_DATA-1:0]   step_mplier_sh;

  pa_shift_add_step #(
    .SIZE_DATA (SIZE_DATA)
  ) u_step (
    .acc_i       (acc_q),
    .mcand_sh_i  (mcand_sh_q),
    .mplier_sh_i (mplier_sh_q),
    .acc_o       (step_acc),
    .mcand_sh_o  (step_mcand_sh),
    .mplier_sh_o (step_mplier_sh)
  );

  // Next-state logic: capture operands in IDLE, iterate in RUN, publish on the last step.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_sh_d  = mcand_sh_q;
    mplier_sh_d = mplier_sh_q;
    cnt_d       = cnt_q;
    product_d   = product_q;
    valid_d     = 1'b0;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (i_en_multiply) begin
          acc_d       = {{SIZE_DATA{1'b0}}, i_addend};
          mcand_sh_d  = {{SIZE_DATA{1'b0}}, i_multiplicand};
          mplier_sh_d = i_multiplier;
          cnt_d       = '0;
          busy_d      = 1'b1;
          state_d     = RUN;
        end
      end
      RUN: begin
        acc_d       = step_acc;
        mcand_sh_d  = step_mcand_sh;
        mplier_sh_d = step_mplier_sh;
        cnt_d       = cnt_q + CNT_W'(1);
        // No early exit on zero operands, so latency never depends on data.
        if (cnt_q == CNT_LAST) begin
          product_d = step_acc;
          valid_d   = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_sh_q  <= '0;
      mplier_sh_q <= '0;
      cnt_q       <= '0;
      product_q   <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_sh_q  <= mcand_sh_d;
      mplier_sh_q <= mplier_sh_d;
      cnt_q       <= cnt_d;
      product_q   <= product_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
    end
  end

  assign o_product = product_q;
  assign o_valid   = valid_q;
  assign o_busy    = busy_q;

endmodule
